// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// exception causes and the LSU FSM state type.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_ADEL    = 2'b01,
    EXC_ADES    = 2'b10,
    EXC_TIMEOUT = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_EXC
  } lsu_state_e;

  function automatic exc_cause_e addr_cause(input logic wr);
    return wr ? EXC_ADES : EXC_ADEL;
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational alignment check for a data access.
// Ports: size (access size), addr_lo (address bits [1:0]) -> misaligned.
module lsu_align_check
  import mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b1;
    unique case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = addr_lo[0];
      MEM_WORD: misaligned = (addr_lo != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: takes one op from EX (req*), drives the
// DataMemory request (mem*), holds it across memStall, then returns load
// data (resp*) or an alignment/timeout exception (exc*); pipeStall freezes
// upstream while an access is in flight. Reset rst is synchronous active-low.
// Build option LSU_ALIGN_CHECK_EN: reject misaligned ops at accept time,
// before they reach memory.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int MAX_STALL = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSign,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  input  logic [REG_W-1:0]  reqDest,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic              memWrite,
  output logic              memRead,
  output logic [1:0]        memSize,
  output logic              memSign,
  input  logic [DATA_W-1:0] memDout,
  input  logic              memStall,
  input  logic              memExc,
  output logic              pipeStall,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic [REG_W-1:0]  respDest,
  output logic              respWe,
  output logic              excValid,
  output logic [1:0]        excCause,
  output logic [ADDR_W-1:0] excBadAddr
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              we_q, we_d;
  exc_cause_e        cause_q, cause_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic              misalign;
  logic              timeout;

`ifdef LSU_ALIGN_CHECK_EN
  lsu_align_check u_align (
    .size      (reqSize),
    .addr_lo   (reqAddr[1:0]),
    .misaligned(misalign)
  );
`else
  assign misalign = 1'b0;
`endif

  // The counter leaves ACCESS on reaching MAX_CNT, so it never wraps.
  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 8'd1;
  assign timeout = (cnt_inc == MAX_CNT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      size_q  <= MEM_WORD;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      cause_q <= EXC_NONE;
      bad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      cause_q <= cause_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) state_d = misalign ? S_EXC : S_ACCESS;
      end
      S_ACCESS: begin
        if (memExc)        state_d = S_EXC;
        else if (memStall) state_d = timeout ? S_EXC : S_ACCESS;
        else               state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    din_d   = din_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    dest_d  = dest_q;
    we_d    = we_q;
    cause_d = cause_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          addr_d = reqAddr;
          din_d  = reqData;
          size_d = reqSize;
          sign_d = reqSign;
          dest_d = reqWrite ? '0 : reqDest;
          cnt_d  = '0;
          // A rejected op never raises a strobe, so a bad store
          // cannot reach memory.
          if (misalign) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            cause_d = addr_cause(reqWrite);
            bad_d   = reqAddr;
          end else begin
            wr_d = reqWrite;
            rd_d = !reqWrite;
          end
        end
      end
      S_ACCESS: begin
        if (memExc) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          cause_d = addr_cause(wr_q);
          bad_d   = addr_q;
        end else if (memStall) begin
          cnt_d = cnt_inc;
          if (timeout) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            cause_d = EXC_TIMEOUT;
            bad_d   = addr_q;
          end
        end else begin
          rdata_d = wr_q ? '0 : memDout;
          we_d    = !wr_q;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == S_IDLE);
    pipeStall = (state_q == S_ACCESS);
    respValid = (state_q == S_RESP);
    excValid  = (state_q == S_EXC);
  end

  assign memAddr    = addr_q;
  assign memDin     = din_q;
  assign memWrite   = wr_q;
  assign memRead    = rd_q;
  assign memSize    = size_q;
  assign memSign    = sign_q;
  assign respData   = rdata_q;
  assign respDest   = dest_q;
  assign respWe     = we_q;
  assign excCause   = cause_q;
  assign excBadAddr = bad_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a byte-array DataMemory model
// and a response scoreboard; also exercises lsu_align_check directly.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic        reqSign = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqData = '0;
  logic [4:0]  reqDest = '0;
  logic [31:0] memAddr, memDin, memDout;
  logic        memWrite, memRead, memSign;
  logic [1:0]  memSize;
  logic        memStall = 1'b0;
  logic        memExc;
  logic        pipeStall, respValid, respWe, excValid;
  logic [31:0] respData, excBadAddr;
  logic [4:0]  respDest;
  logic [1:0]  excCause;

  always #5 clk = ~clk;

  mem_stage_lsu #(
    .ADDR_W(32), .DATA_W(32), .REG_W(5), .MAX_STALL(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSign(reqSign), .reqAddr(reqAddr),
    .reqData(reqData), .reqDest(reqDest),
    .memAddr(memAddr), .memDin(memDin),
    .memWrite(memWrite), .memRead(memRead),
    .memSize(memSize), .memSign(memSign),
    .memDout(memDout), .memStall(memStall),
    .memExc(memExc), .pipeStall(pipeStall),
    .respValid(respValid), .respData(respData),
    .respDest(respDest), .respWe(respWe),
    .excValid(excValid), .excCause(excCause),
    .excBadAddr(excBadAddr)
  );

  logic [1:0] ac_size = '0;
  logic [1:0] ac_lo = '0;
  logic       ac_mis;

  lsu_align_check u_ac (
    .size(ac_size), .addr_lo(ac_lo), .misaligned(ac_mis)
  );

  // DataMemory model: 16 bytes, little-endian, extends loads itself.
  logic [7:0] mem [16];
  logic [3:0] ma;
  logic       clr = 1'b1;

  function automatic logic bad_al(input logic [1:0] s,
                                  input logic [1:0] lo);
    if (s == 2'b00) return 1'b0;
    if (s == 2'b01) return lo[0];
    if (s == 2'b10) return lo != 2'b00;
    return 1'b1;
  endfunction

  assign ma = memAddr[3:0];
  assign memExc = (memRead | memWrite) && bad_al(memSize, memAddr[1:0]);

  always_comb begin
    memDout = '0;
    case (memSize)
      2'b00: memDout = memSign ? {{24{mem[ma][7]}}, mem[ma]}
                               : {24'b0, mem[ma]};
      2'b01: memDout = memSign
        ? {{16{mem[ma+4'd1][7]}}, mem[ma+4'd1], mem[ma]}
        : {16'b0, mem[ma+4'd1], mem[ma]};
      default: memDout = {mem[ma+4'd3], mem[ma+4'd2],
                          mem[ma+4'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[6] <= 8'hFF;
      mem[7] <= 8'hEE;
    end else if (memWrite && !memStall && !memExc) begin
      mem[ma] <= memDin[7:0];
      if (memSize != 2'b00) mem[ma+4'd1] <= memDin[15:8];
      if (memSize == 2'b10) begin
        mem[ma+4'd2] <= memDin[23:16];
        mem[ma+4'd3] <= memDin[31:24];
      end
    end
  end

  int resp_cnt = 0;
  int exc_cnt = 0;
  int wr_cyc = 0;

  always @(negedge clk) begin
    if (respValid) resp_cnt++;
    if (excValid) exc_cnt++;
    if (memWrite) wr_cyc++;
  end

  typedef struct {
    bit          exc;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic [1:0]  cause;
    logic [31:0] bad;
    int          lat;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] dst,
                       input int nst);
    @(negedge clk);
    chk("reqReady", 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqWrite = wr;
    reqSize = sz;
    reqSign = sg;
    reqAddr = a;
    reqData = d;
    reqDest = dst;
    memStall = (nst > 0);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int nst);
    int k;
    int ps;
    bit got;
    exp_t e;
    k = 1;
    ps = 0;
    got = 1'b0;
    while (k <= 40 && !got) begin
      if (k > nst) memStall = 1'b0;
      if (respValid || excValid) got = 1'b1;
      else begin
        if (pipeStall) ps++;
        @(negedge clk);
        k++;
      end
    end
    chk({tag, ".seen"}, 32'(got), 32'd1);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".exc"}, 32'(excValid), 32'(e.exc));
      chk({tag, ".resp"}, 32'(respValid), 32'(!e.exc));
      chk({tag, ".lat"}, 32'(k), 32'(e.lat));
      chk({tag, ".stall"}, 32'(ps), 32'(e.stalls));
      if (e.exc) begin
        chk({tag, ".cause"}, 32'(excCause), 32'(e.cause));
        chk({tag, ".bad"}, excBadAddr, e.bad);
      end else begin
        chk({tag, ".data"}, respData, e.data);
        chk({tag, ".dest"}, 32'(respDest), 32'(e.dest));
        chk({tag, ".we"}, 32'(respWe), 32'(e.we));
      end
    end
    memStall = 1'b0;
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(respValid | excValid), 32'd0);
    chk({tag, ".idle"}, 32'(reqReady), 32'd1);
  endtask

  initial begin
    int w0;
    int r0;
    int x0;
    logic [2:0] av [6];
    logic [5:0] ac_tab [6];

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.memRead", 32'(memRead), 32'd0);
    chk("rst.memWrite", 32'(memWrite), 32'd0);
    chk("rst.respValid", 32'(respValid), 32'd0);
    chk("rst.excValid", 32'(excValid), 32'd0);
    chk("rst.pipeStall", 32'(pipeStall), 32'd0);
    chk("rst.memSize", 32'(memSize), 32'd2);
    chk("rst.memAddr", memAddr, 32'd0);
    chk("rst.reqReady", 32'(reqReady), 32'd1);
    rst = 1'b1;
    clr = 1'b0;

    // store word, no stall; a store reports no data and no dest
    w0 = wr_cyc;
    sbq.push_back('{1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 2, 1});
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, 5'd9, 0);
    chk("st.memWrite", 32'(memWrite), 32'd1);
    chk("st.memRead", 32'(memRead), 32'd0);
    chk("st.memAddr", memAddr, 32'h0);
    chk("st.memDin", memDin, 32'h12345678);
    wait_resp("st", 0);
    chk("st.wrcyc", 32'(wr_cyc - w0), 32'd1);

    // load half signed from bytes 6-7 with one stall cycle
    sbq.push_back('{1'b0, 32'hFFFFEEFF, 5'd7, 1'b1, 2'b00, 32'h0, 3, 2});
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 5'd7, 1);
    chk("ldh.memRead", 32'(memRead), 32'd1);
    wait_resp("ldh", 1);

    // load byte unsigned from the byte the store wrote, two stalls
    sbq.push_back('{1'b0, 32'h00000078, 5'd3, 1'b1, 2'b00, 32'h0, 4, 3});
    issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd3, 2);
    wait_resp("ldb", 2);

    // misaligned store word at 0x3
    w0 = wr_cyc;
    r0 = resp_cnt;
`ifdef LSU_ALIGN_CHECK_EN
    sbq.push_back('{1'b1, 32'h0, 5'd0, 1'b0, 2'b10, 32'h3, 1, 0});
`else
    sbq.push_back('{1'b1, 32'h0, 5'd0, 1'b0, 2'b10, 32'h3, 2, 1});
`endif
    issue(1'b1, 2'b10, 1'b0, 32'h3, 32'hAABBCCDD, 5'd1, 0);
    wait_resp("mis", 0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis.wrcyc", 32'(wr_cyc - w0), 32'd0);
`else
    chk("mis.wrcyc", 32'(wr_cyc - w0), 32'd1);
`endif
    chk("mis.noresp", 32'(resp_cnt - r0), 32'd0);
    chk("mis.mem3", 32'(mem[3]), 32'h12);

    // timeout: stall held forever
    sbq.push_back('{1'b1, 32'h0, 5'd0, 1'b0, 2'b11, 32'h8, 5, 4});
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd4, 1000);
    wait_resp("tmo", 1000);

    // reset while an access is stalled
    r0 = resp_cnt;
    x0 = exc_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd5, 1);
    chk("rma.access", 32'(pipeStall), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    memStall = 1'b0;
    chk("rma.memRead", 32'(memRead), 32'd0);
    chk("rma.reqReady", 32'(reqReady), 32'd1);
    chk("rma.pipeStall", 32'(pipeStall), 32'd0);
    repeat (6) @(negedge clk);
    chk("rma.noresp", 32'(resp_cnt - r0), 32'd0);
    chk("rma.noexc", 32'(exc_cnt - x0), 32'd0);

    // normal operation after the reset
    sbq.push_back('{1'b0, 32'hEEFF0000, 5'd12, 1'b1, 2'b00, 32'h0, 2, 1});
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd12, 0);
    wait_resp("ldw", 0);

    // standalone alignment checker: {size, lo, expected}
    ac_tab[0] = {2'b00, 2'b11, 1'b0, 1'b0};
    ac_tab[1] = {2'b01, 2'b00, 1'b0, 1'b0};
    ac_tab[2] = {2'b01, 2'b01, 1'b1, 1'b0};
    ac_tab[3] = {2'b10, 2'b00, 1'b0, 1'b0};
    ac_tab[4] = {2'b10, 2'b10, 1'b1, 1'b0};
    ac_tab[5] = {2'b11, 2'b00, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      av[i] = ac_tab[i][5:3];
      ac_size = ac_tab[i][5:4];
      ac_lo = ac_tab[i][3:2];
      #1;
      chk("align", 32'(ac_mis), 32'(ac_tab[i][1]));
    end

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
